counter4b_rev: RTL and testbench

- Synchronous reversible (up/down) binary counter, 4 bits wide by default.
- Direction input S selects count up or count down.
- Ripple-carry/borrow output Rc flags the terminal count so several instances can be cascaded.
- Used as a leaf counter in lab-level datapaths and driven by the system clock.

---
 rtl/counter4b_rev.sv | 37 +++
 tb/tb_counter4b_rev.sv | 138 +++++++++++++
 2 files changed

// File: rtl/counter4b_rev.sv
// Reversible binary counter: S=1 counts up, S=0 counts down, one step per clk edge.
// Rc flags the terminal count for the current direction so stages can be cascaded.
module counter4b_rev #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             S,
  output logic [WIDTH-1:0] cnt,
  output logic             Rc
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = S ? (cnt_q + ONE) : (cnt_q - ONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Decoded straight from S so a direction change moves Rc without a clock edge.
  always_comb begin
    Rc = S ? (&cnt_q) : ~(|cnt_q);
  end

  assign cnt = cnt_q;

endmodule

// File: tb/tb_counter4b_rev.sv
// Randomised and directed bench for counter4b_rev against an arithmetic reference model.
module tb_counter4b_rev;

  localparam int WIDTH = 4;
  localparam int MODV  = 1 << WIDTH;

  logic             clk;
  logic             rst;
  logic             s;
  logic [WIDTH-1:0] cnt;
  logic             rc;

  int n_tests = 0;
  int n_fail  = 0;
  int ref_cnt = 0;

  counter4b_rev #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .S   (s),
    .cnt (cnt),
    .Rc  (rc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ref_rc(input int c, input logic dir);
    return dir ? (c == MODV - 1) : (c == 0);
  endfunction

  // One clock edge: advance the model using S as seen at the edge, then check 1ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) ref_cnt = s ? (ref_cnt + 1) % MODV : (ref_cnt + MODV - 1) % MODV;
    #1;
    check({tag, "_cnt"}, 32'(cnt), 32'(ref_cnt));
    check({tag, "_rc"}, 32'(rc), 32'(ref_rc(ref_cnt, s)));
  endtask

  task automatic do_reset(input logic dir);
    rst = 1'b0;
    s = dir;
    ref_cnt = 0;
    #1;
    check("rst_assert_cnt", 32'(cnt), 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    s   = 1'b0;
    ref_cnt = 0;

    // Held in reset with S=0: cnt pinned at zero, Rc high.
    for (int i = 0; i < 5; i++) begin
      tick("rst_hold");
      check("rst_hold_const", 32'(cnt), 32'd0);
    end
    s = 1'b1;
    #1;
    check("rst_s1_rc", 32'(rc), 32'd0);
    check("rst_s1_cnt", 32'(cnt), 32'd0);

    // Up count through a full wrap.
    rst = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick("up");
      check("up_abs", 32'(cnt), 32'(i % 16));
    end

    // Down count through a full wrap.
    do_reset(1'b0);
    for (int i = 1; i <= 16; i++) begin
      tick("down");
      check("down_abs", 32'(cnt), 32'((16 - i) % 16));
    end

    // Direction switch mid-cycle.
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) tick("dir_up");
    check("dir_at5", 32'(cnt), 32'd5);
    #3 s = 1'b0;
    tick("dir_dn1");
    check("dir_dn1_abs", 32'(cnt), 32'd4);
    tick("dir_dn2");
    check("dir_dn2_abs", 32'(cnt), 32'd3);
    s = 1'b1;
    tick("dir_up2");
    check("dir_up2_abs", 32'(cnt), 32'd4);

    // Asynchronous reset between edges.
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) tick("pre_async");
    check("at_1010", 32'(cnt), 32'd10);
    #3 rst = 1'b0;
    ref_cnt = 0;
    #1;
    check("async_rst_cnt", 32'(cnt), 32'd0);
    #1 rst = 1'b1;
    tick("post_async");
    check("post_async_abs", 32'(cnt), 32'd1);

    // Rc responds to S without a clock edge.
    for (int i = 0; i < 20 && ref_cnt != MODV - 1; i++) tick("to_max");
    check("at_max", 32'(cnt), 32'(MODV - 1));
    check("max_rc_up", 32'(rc), 32'd1);
    s = 1'b0;
    #1;
    check("max_rc_flip", 32'(rc), 32'd0);

    // Random direction with occasional mid-cycle reset pulses.
    for (int i = 0; i < 300; i++) begin
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        #3 rst = 1'b0;
        ref_cnt = 0;
        #1;
        check("rnd_rst_cnt", 32'(cnt), 32'd0);
        check("rnd_rst_rc", 32'(rc), 32'(ref_rc(0, s)));
        #1 rst = 1'b1;
      end
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
